// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad column scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } kp_state_t;

    localparam int KP_N = 4;

    function automatic logic [1:0] onehot_low_idx(input logic [3:0] v);
        logic [1:0] idx;
        casez (v)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider; tick is high on the last count of every DIV-cycle period.
module scan_tick_gen #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/keypad_col_scanner.sv
// 4x4 keypad scanner: one-hot column drive, row debounce, key code with one-cycle valid strobe.
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV      = 50000,
    parameter int unsigned STABLE_TICKS  = 4,
    parameter int unsigned RELEASE_TICKS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [KP_N-1:0] filas_in,
    output logic [KP_N-1:0] columnas_out,
    output logic [3:0]      key_code,
    output logic            key_valid,
    output logic            key_held
);

    localparam int unsigned MAX_TICKS = (STABLE_TICKS > RELEASE_TICKS) ? STABLE_TICKS
                                                                       : RELEASE_TICKS;
    localparam int unsigned CW = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] STABLE_CNT  = CW'(STABLE_TICKS);
    localparam logic [CW-1:0] RELEASE_CNT = CW'(RELEASE_TICKS);
    localparam logic [CW-1:0] ONE_CNT     = CW'(1);

    logic            tick;
    logic [KP_N-1:0] filas_meta_q;
    logic [KP_N-1:0] filas_sync_q;
    kp_state_t       state_q;
    logic [KP_N-1:0] col_q;
    logic [KP_N-1:0] captured_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_inc;
    logic [3:0]      code_q;
    logic            valid_q;
    logic            held_q;

    scan_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            filas_meta_q <= '0;
            filas_sync_q <= '0;
        end else begin
            filas_meta_q <= filas_in;
            filas_sync_q <= filas_meta_q;
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCAN;
            col_q      <= 4'b0001;
            captured_q <= '0;
            cnt_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                SCAN: begin
                    if (tick) begin
                        if (filas_sync_q != '0) begin
                            captured_q <= filas_sync_q;
                            cnt_q      <= ONE_CNT;
                            state_q    <= DEBOUNCE;
                        end else begin
                            col_q <= {col_q[KP_N-2:0], col_q[KP_N-1]};
                        end
                    end
                end
                DEBOUNCE: begin
                    if (tick) begin
                        if (filas_sync_q == '0) begin
                            // Column left where it is; the next SCAN tick moves it on.
                            state_q <= SCAN;
                        end else if (filas_sync_q == captured_q) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == STABLE_CNT) begin
                                state_q <= PRESSED;
                                valid_q <= 1'b1;
                                held_q  <= 1'b1;
                                code_q  <= {onehot_low_idx(captured_q), onehot_low_idx(col_q)};
                            end
                        end else begin
                            captured_q <= filas_sync_q;
                            cnt_q      <= ONE_CNT;
                        end
                    end
                end
                PRESSED: begin
                    state_q <= RELEASE;
                    cnt_q   <= '0;
                end
                RELEASE: begin
                    if (tick) begin
                        if (filas_sync_q == '0) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == RELEASE_CNT) begin
                                state_q <= SCAN;
                                held_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign columnas_out = col_q;
    assign key_code     = code_q;
    assign key_valid    = valid_q;
    assign key_held     = held_q;

endmodule

// File: tb/tb_keypad_col_scanner.sv
// Directed bench with a keypad model, expected-code scoreboard and a key_valid monitor.
module tb_keypad_col_scanner;

    localparam int unsigned SCAN_DIV      = 4;
    localparam int unsigned STABLE_TICKS  = 3;
    localparam int unsigned RELEASE_TICKS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] filas_in;
    logic [3:0] columnas_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // Keypad model: rows close only while the pressed key's column is driven.
    logic       key_down = 1'b0;
    logic [3:0] key_col  = 4'b0000;
    logic [3:0] key_row  = 4'b0000;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    assign filas_in = (key_down && ((columnas_out & key_col) != 4'b0000)) ? key_row : 4'b0000;

    always #5 clk = ~clk;

    keypad_col_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .STABLE_TICKS  (STABLE_TICKS),
        .RELEASE_TICKS (RELEASE_TICKS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .filas_in     (filas_in),
        .columnas_out (columnas_out),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_held     (key_held)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && key_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected key_valid: got code %0h expected no pulse", key_code);
            end else begin
                check("scoreboard key_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_col_change(output logic [3:0] col, output int n);
        logic [3:0] prev;
        prev = columnas_out;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (columnas_out == prev && n < 64);
        col = columnas_out;
    endtask

    task automatic wait_col(input logic [3:0] want);
        logic [3:0] col;
        int n;
        col = columnas_out;
        for (int i = 0; i < 5 && col != want; i++) wait_col_change(col, n);
        check("reach column", {28'd0, columnas_out}, {28'd0, want});
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!key_valid && n < 200);
    endtask

    task automatic wait_held_low(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (key_held && n < 200);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " columnas_out"}, {28'd0, columnas_out}, 32'h1);
        check({tag, " key_code"}, {28'd0, key_code}, 32'h0);
        check({tag, " key_valid"}, {31'd0, key_valid}, 32'h0);
        check({tag, " key_held"}, {31'd0, key_held}, 32'h0);
    endtask

    initial begin
        logic [3:0] col;
        int n;
        int low_cnt;
        logic [3:0] idle_seq [4];

        idle_seq[0] = 4'b0010;
        idle_seq[1] = 4'b0100;
        idle_seq[2] = 4'b1000;
        idle_seq[3] = 4'b0001;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Idle scan: rotate every SCAN_DIV clocks.
        for (int i = 0; i < 4; i++) begin
            wait_col_change(col, n);
            check("idle column", {28'd0, col}, {28'd0, idle_seq[i]});
            check("idle spacing", n, 4);
        end

        // Clean press at column 0010, row 2 -> code 9.
        wait_col_change(col, n);
        check("clean column", {28'd0, col}, 32'h2);
        key_col = 4'b0010;
        key_row = 4'b0100;
        key_down = 1'b1;
        exp_q.push_back(4'h9);
        wait_valid(n);
        check("clean latency", n, 12);
        check("clean held", {31'd0, key_held}, 32'h1);
        check("clean frozen column", {28'd0, columnas_out}, 32'h2);
        key_down = 1'b0;
        wait_held_low(n);
        check("clean release latency", n, 12);
        check("clean key_code kept", {28'd0, key_code}, 32'h9);
        wait_col_change(col, n);
        check("resume column", {28'd0, col}, 32'h4);
        check("resume spacing", n, 4);

        // Bounce: alternate on/off every tick, then hold.
        wait_col(4'b0010);
        for (int i = 0; i < 3; i++) begin
            key_down = 1'b1;
            repeat (4) @(negedge clk);
            key_down = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("bounce frozen column", {28'd0, columnas_out}, 32'h2);
        check("bounce no held", {31'd0, key_held}, 32'h0);
        key_down = 1'b1;
        exp_q.push_back(4'h9);
        wait_valid(n);
        check("bounce latency", n, 12);
        key_down = 1'b0;
        wait_held_low(n);
        check("bounce release latency", n, 12);

        // Multi-row at column 0001: rows 1 and 3 -> row 1 wins -> code 4.
        wait_col(4'b0001);
        key_col = 4'b0001;
        key_row = 4'b1010;
        key_down = 1'b1;
        exp_q.push_back(4'h4);
        wait_valid(n);
        check("multi latency", n, 12);
        low_cnt = 0;
        repeat (20 * SCAN_DIV) begin
            @(negedge clk);
            if (!key_held) low_cnt++;
        end
        check("multi held low cycles", low_cnt, 0);
        check("multi frozen column", {28'd0, columnas_out}, 32'h1);
        check("multi key_code", {28'd0, key_code}, 32'h4);
        key_down = 1'b0;
        wait_held_low(n);
        check("multi release latency", n, 12);

        // Reset in DEBOUNCE.
        wait_col(4'b0100);
        key_col = 4'b0100;
        key_row = 4'b0001;
        key_down = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        key_down = 1'b0;
        @(negedge clk);
        check_reset_values("rst debounce");
        rst = 1'b0;
        wait_col_change(col, n);
        check("restart column", {28'd0, col}, 32'h2);
        check("restart spacing", n, 4);

        // Reset in RELEASE, column 1000 row 1 -> code 7.
        wait_col(4'b1000);
        key_col = 4'b1000;
        key_row = 4'b0010;
        key_down = 1'b1;
        exp_q.push_back(4'h7);
        wait_valid(n);
        check("release-reset latency", n, 12);
        repeat (2) @(negedge clk);
        check("in release held", {31'd0, key_held}, 32'h1);
        rst = 1'b1;
        key_down = 1'b0;
        @(negedge clk);
        check_reset_values("rst release");
        rst = 1'b0;
        wait_col_change(col, n);
        check("restart2 column", {28'd0, col}, 32'h2);
        check("restart2 spacing", n, 4);

        repeat (20) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
